// File: rtl/vec_register_file_pkg.sv
// Purpose: shared constants, FSM state type and staging record for the
// vector register file.
// Contents: VLEN/SEW/NREG/ADDR_W, wb_state_e, stage_s, grp_aligned().
package vec_regfile_pkg;
  localparam int VLEN   = 512;
  localparam int SEW    = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = $clog2(NREG);

  typedef enum logic {IDLE, WRITE} wb_state_e;

  // One staged register slice. A grouped write stages LMUL of these, one
  // per member register of the group.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VLEN-1:0]   data;
    logic              vm;
  } stage_s;

  function automatic logic grp_aligned(input logic [ADDR_W-1:0] addr, input int lmul);
    return (int'(addr) % lmul) == 0;
  endfunction
endpackage

// File: rtl/vec_register_file_if.sv
// Purpose: write-side request/handshake bundle of the vector register file.
// Signals: wr_en, waddr, wdata, vm (requester -> file);
//          wr_ready, wr_done, wr_err (file -> requester).
interface vec_register_file_if #(parameter int LMUL = 1);
  import vec_regfile_pkg::*;

  logic                   wr_en;
  logic [ADDR_W-1:0]      waddr;
  logic [VLEN*LMUL-1:0]   wdata;
  logic                   vm;
  logic                   wr_ready;
  logic                   wr_done;
  logic                   wr_err;

  modport master (output wr_en, waddr, wdata, vm, input wr_ready, wr_done, wr_err);
  modport slave  (input wr_en, waddr, wdata, vm, output wr_ready, wr_done, wr_err);
endinterface

// File: rtl/vec_mask_merge.sv
// Purpose: per-element merge of new and old group data under the v0 mask.
// Ports: new_data/old_data (grouped data), mask (v0 bits, one per element),
//        vm (1 = unmasked), merged (result).
module vec_mask_merge import vec_regfile_pkg::*; #(
  parameter int LMUL = 1
) (
  input  logic [VLEN*LMUL-1:0]     new_data,
  input  logic [VLEN*LMUL-1:0]     old_data,
  input  logic [VLEN*LMUL/SEW-1:0] mask,
  input  logic                     vm,
  output logic [VLEN*LMUL-1:0]     merged
);
  localparam int ELEMS = VLEN*LMUL/SEW;

  always_comb begin
    merged = old_data;
    for (int i = 0; i < ELEMS; i++) begin
      if (vm || mask[i]) merged[i*SEW +: SEW] = new_data[i*SEW +: SEW];
    end
  end
endmodule

// File: rtl/vec_register_file.sv
// Purpose: 32 x VLEN vector register file with LMUL grouping, two
// combinational grouped read ports, v0 mask output and a staged,
// two-state write commit with ready/done/err handshake.
// Ports: clk, n_rst (async active-low), raddr_1/raddr_2 -> rdata_1/rdata_2,
//        vmask (v0), wr (write interface, slave side).
//
// state | meaning
// IDLE  | staging free, wr_ready high, requests checked and captured
// WRITE | staged group committed to the array at the next edge
module vec_register_file import vec_regfile_pkg::*; #(
  parameter int LMUL = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [ADDR_W-1:0]    raddr_1,
  input  logic [ADDR_W-1:0]    raddr_2,
  output logic [VLEN*LMUL-1:0] rdata_1,
  output logic [VLEN*LMUL-1:0] rdata_2,
  output logic [VLEN-1:0]      vmask,
  vec_register_file_if.slave   wr
);
  localparam int GW    = VLEN*LMUL;
  localparam int ELEMS = GW/SEW;

  logic [VLEN-1:0] regs [NREG];
  stage_s          stage [LMUL];
  wb_state_e       state_q, state_d;
  logic            capture, commit, err_d, req_legal;
  logic            done_q, err_q;
  logic [GW-1:0]   stage_data, old_data, merged;

  assign vmask = regs[0];

  always_comb begin
    rdata_1 = '0;
    rdata_2 = '0;
    for (int j = 0; j < LMUL; j++) begin
      if (grp_aligned(raddr_1, LMUL) && (int'(raddr_1) + j < NREG))
        rdata_1[j*VLEN +: VLEN] = regs[raddr_1 + ADDR_W'(j)];
      if (grp_aligned(raddr_2, LMUL) && (int'(raddr_2) + j < NREG))
        rdata_2[j*VLEN +: VLEN] = regs[raddr_2 + ADDR_W'(j)];
    end
  end

  // A masked write must never target v0, the mask source itself.
  assign req_legal = grp_aligned(wr.waddr, LMUL) &&
                     (int'(wr.waddr) + LMUL <= NREG) &&
                     !(!wr.vm && (wr.waddr == '0));

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    commit      = 1'b0;
    err_d       = 1'b0;
    wr.wr_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (wr.wr_en) begin
          if (req_legal) begin
            capture = 1'b1;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr.wr_done = done_q;
  assign wr.wr_err  = err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= commit;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int j = 0; j < LMUL; j++) stage[j] <= '0;
    end else if (capture) begin
      for (int j = 0; j < LMUL; j++)
        stage[j] <= '{addr: wr.waddr + ADDR_W'(j),
                      data: wr.wdata[j*VLEN +: VLEN],
                      vm:   wr.vm};
    end
  end

  always_comb begin
    stage_data = '0;
    old_data   = '0;
    for (int j = 0; j < LMUL; j++) begin
      stage_data[j*VLEN +: VLEN] = stage[j].data;
      old_data[j*VLEN +: VLEN]   = regs[stage[j].addr];
    end
  end

  // v0 is read live, so the mask seen is the one present at the commit edge.
  vec_mask_merge #(.LMUL(LMUL)) u_merge (
    .new_data (stage_data),
    .old_data (old_data),
    .mask     (regs[0][ELEMS-1:0]),
    .vm       (stage[0].vm),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (commit) begin
      for (int j = 0; j < LMUL; j++) regs[stage[j].addr] <= merged[j*VLEN +: VLEN];
    end
  end
endmodule

// File: tb/tb_vec_register_file.sv
// Purpose: directed self-checking bench for vec_register_file, covering an
// LMUL=1 instance and an LMUL=2 instance plus a small load-unit model.
module tb_vec_register_file;
  import vec_regfile_pkg::*;

  localparam logic [511:0] PAT_A5 = {64{8'hA5}};
  localparam logic [511:0] PAT_X  = {16{32'h1234_5678}};
  localparam logic [511:0] PAT_Y  = {16{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    r1_a1, r1_a2, r2_a1, r2_a2;
  logic [511:0]  r1_d1, r1_d2, vm1;
  logic [1023:0] r2_d1, r2_d2;
  logic [511:0]  vm2;

  vec_register_file_if #(.LMUL(1)) w1 ();
  vec_register_file_if #(.LMUL(2)) w2 ();

  vec_register_file #(.LMUL(1)) u_dut (
    .clk(clk), .n_rst(n_rst), .raddr_1(r1_a1), .raddr_2(r1_a2),
    .rdata_1(r1_d1), .rdata_2(r1_d2), .vmask(vm1), .wr(w1));

  vec_register_file #(.LMUL(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .raddr_1(r2_a1), .raddr_2(r2_a2),
    .rdata_1(r2_d1), .rdata_2(r2_d2), .vmask(vm2), .wr(w2));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [256];

  // Issue one single-cycle request on the LMUL=1 port and record on which
  // sample (1 = just after the request edge) done/err were first seen.
  task automatic wr1(input logic [4:0] a, input logic [511:0] d, input logic v,
                     output int done_cyc, output int err_cyc, output int done_n);
    w1.waddr = a; w1.wdata = d; w1.vm = v; w1.wr_en = 1'b1;
    @(posedge clk); #1;
    w1.wr_en = 1'b0;
    done_cyc = 0; err_cyc = 0; done_n = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (w1.wr_done) begin done_n++; if (done_cyc == 0) done_cyc = c; end
      if (w1.wr_err && err_cyc == 0) err_cyc = c;
    end
  endtask

  task automatic wr2(input logic [4:0] a, input logic [1023:0] d, input logic v,
                     output int done_cyc, output int err_cyc, output int done_n);
    w2.waddr = a; w2.wdata = d; w2.vm = v; w2.wr_en = 1'b1;
    @(posedge clk); #1;
    w2.wr_en = 1'b0;
    done_cyc = 0; err_cyc = 0; done_n = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (w2.wr_done) begin done_n++; if (done_cyc == 0) done_cyc = c; end
      if (w2.wr_err && err_cyc == 0) err_cyc = c;
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (w1.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_in_reset got %b want 1", w1.wr_ready); end
    n_tests++; if (r1_d1 !== '0) begin n_fail++; $display("FAIL rst_rdata_in_reset got %h want 0", r1_d1); end
    #10 n_rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (w1.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", w1.wr_ready); end
    n_tests++; if (w1.wr_done !== 1'b0 || w1.wr_err !== 1'b0) begin n_fail++; $display("FAIL rst_done_err got %b%b want 00", w1.wr_done, w1.wr_err); end
    n_tests++; if (w2.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready2 got %b want 1", w2.wr_ready); end
    n_tests++; if (vm1 !== '0) begin n_fail++; $display("FAIL rst_vmask got %h want 0", vm1); end
    for (int i = 0; i < 32; i++) begin
      r1_a1 = 5'(i); r1_a2 = 5'(31 - i); #1;
      n_tests++; if (r1_d1 !== '0) begin n_fail++; $display("FAIL rst_read1 reg%0d got %h want 0", i, r1_d1); end
      n_tests++; if (r1_d2 !== '0) begin n_fail++; $display("FAIL rst_read2 reg%0d got %h want 0", 31 - i, r1_d2); end
    end
  endtask

  task automatic test_unmasked();
    r1_a1 = 5'd3;
    w1.waddr = 5'd3; w1.wdata = PAT_A5; w1.vm = 1'b1; w1.wr_en = 1'b1;
    #1;
    n_tests++; if (w1.wr_ready !== 1'b1) begin n_fail++; $display("FAIL um_ready_pre got %b want 1", w1.wr_ready); end
    @(posedge clk); #1;
    w1.wr_en = 1'b0;
    n_tests++; if (w1.wr_ready !== 1'b0) begin n_fail++; $display("FAIL um_ready_busy got %b want 0", w1.wr_ready); end
    n_tests++; if (w1.wr_done !== 1'b0) begin n_fail++; $display("FAIL um_done_early got %b want 0", w1.wr_done); end
    n_tests++; if (r1_d1 !== '0) begin n_fail++; $display("FAIL um_no_bypass got %h want 0", r1_d1); end
    @(posedge clk); #1;
    n_tests++; if (w1.wr_done !== 1'b1) begin n_fail++; $display("FAIL um_done got %b want 1", w1.wr_done); end
    n_tests++; if (w1.wr_ready !== 1'b1) begin n_fail++; $display("FAIL um_ready_back got %b want 1", w1.wr_ready); end
    n_tests++; if (r1_d1 !== PAT_A5) begin n_fail++; $display("FAIL um_data got %h want %h", r1_d1, PAT_A5); end
    @(posedge clk); #1;
    n_tests++; if (w1.wr_done !== 1'b0) begin n_fail++; $display("FAIL um_done_width got %b want 0", w1.wr_done); end
  endtask

  task automatic test_masked();
    int dc, ec, dn;
    wr1(5'd0, {496'b0, 16'h00FF}, 1'b1, dc, ec, dn);
    n_tests++; if (dc != 2) begin n_fail++; $display("FAIL mk_v0_done got %0d want 2", dc); end
    n_tests++; if (vm1 !== {496'b0, 16'h00FF}) begin n_fail++; $display("FAIL mk_vmask got %h want ff", vm1); end
    wr1(5'd5, {512{1'b1}}, 1'b0, dc, ec, dn);
    r1_a1 = 5'd5; #1;
    n_tests++; if (dc != 2 || ec != 0) begin n_fail++; $display("FAIL mk_done got done@%0d err@%0d want 2/0", dc, ec); end
    n_tests++; if (r1_d1 !== {256'b0, {256{1'b1}}}) begin n_fail++; $display("FAIL mk_reg5 got %h", r1_d1); end
    wr1(5'd3, 512'b0, 1'b0, dc, ec, dn);
    r1_a1 = 5'd3; #1;
    n_tests++; if (r1_d1 !== {PAT_A5[511:256], 256'b0}) begin n_fail++; $display("FAIL mk_keep_old got %h", r1_d1); end
  endtask

  task automatic test_illegal();
    int dc, ec, dn;
    wr1(5'd0, {512{1'b1}}, 1'b0, dc, ec, dn);
    n_tests++; if (ec != 1) begin n_fail++; $display("FAIL il_v0_err got %0d want 1", ec); end
    n_tests++; if (dn != 0) begin n_fail++; $display("FAIL il_v0_nodone got %0d want 0", dn); end
    n_tests++; if (vm1 !== {496'b0, 16'h00FF}) begin n_fail++; $display("FAIL il_v0_kept got %h want ff", vm1); end
  endtask

  task automatic test_lmul2();
    int dc, ec, dn;
    wr2(5'd3, {PAT_Y, PAT_X}, 1'b1, dc, ec, dn);
    n_tests++; if (ec != 1 || dn != 0) begin n_fail++; $display("FAIL l2_misalign got err@%0d done=%0d want 1/0", ec, dn); end
    wr2(5'd4, {PAT_Y, PAT_X}, 1'b1, dc, ec, dn);
    n_tests++; if (dc != 2 || ec != 0) begin n_fail++; $display("FAIL l2_done got done@%0d err@%0d want 2/0", dc, ec); end
    r2_a1 = 5'd4; r2_a2 = 5'd5; #1;
    n_tests++; if (r2_d1[511:0] !== PAT_X) begin n_fail++; $display("FAIL l2_reg4 got %h want %h", r2_d1[511:0], PAT_X); end
    n_tests++; if (r2_d1[1023:512] !== PAT_Y) begin n_fail++; $display("FAIL l2_reg5 got %h want %h", r2_d1[1023:512], PAT_Y); end
    n_tests++; if (r2_d2 !== '0) begin n_fail++; $display("FAIL l2_misalign_read got %h want 0", r2_d2[511:0]); end
  endtask

  task automatic test_busy();
    w1.waddr = 5'd6; w1.wdata = PAT_X; w1.vm = 1'b1; w1.wr_en = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (w1.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bz_ready got %b want 0", w1.wr_ready); end
    w1.waddr = 5'd7; w1.wdata = PAT_Y;
    @(posedge clk); #1;
    w1.wr_en = 1'b0;
    n_tests++; if (w1.wr_done !== 1'b1) begin n_fail++; $display("FAIL bz_done got %b want 1", w1.wr_done); end
    r1_a1 = 5'd6; r1_a2 = 5'd7;
    @(posedge clk); #1;
    n_tests++; if (r1_d1 !== PAT_X) begin n_fail++; $display("FAIL bz_reg6 got %h want %h", r1_d1, PAT_X); end
    n_tests++; if (r1_d2 !== '0) begin n_fail++; $display("FAIL bz_reg7 got %h want 0", r1_d2); end
    n_tests++; if (w1.wr_done !== 1'b0) begin n_fail++; $display("FAIL bz_no_second got %b want 0", w1.wr_done); end
  endtask

  // Load-unit model: fetch 16 words from byte base 0x200, then present the
  // assembled vd_data with a one-cycle is_loaded.
  task automatic test_lsu();
    logic [511:0] vd_data, exp;
    int done_n;
    for (int k = 0; k < 256; k++) mem[k] = {16'(k * 4), 16'(k * 3 + 1)} ^ 32'h5A5A_0000;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      vd_data[i*32 +: 32] = mem[(32'h200 >> 2) + i];
    end
    for (int i = 0; i < 16; i++) exp[i*32 +: 32] = {16'(32'h200 + 4 * i), 16'(3 * (128 + i) + 1)} ^ 32'h5A5A_0000;
    w1.waddr = 5'd12; w1.wdata = vd_data; w1.vm = 1'b1; w1.wr_en = 1'b1;
    @(posedge clk); #1;
    w1.wr_en = 1'b0;
    done_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (w1.wr_done) done_n++;
      @(posedge clk); #1;
    end
    r1_a1 = 5'd12; #1;
    n_tests++; if (done_n != 1) begin n_fail++; $display("FAIL lsu_done_count got %0d want 1", done_n); end
    n_tests++; if (r1_d1 !== exp) begin n_fail++; $display("FAIL lsu_data got %h want %h", r1_d1, exp); end
  endtask

  task automatic test_reset_mid();
    r1_a1 = 5'd3; r1_a2 = 5'd9;
    w1.waddr = 5'd9; w1.wdata = PAT_Y; w1.vm = 1'b1; w1.wr_en = 1'b1;
    @(posedge clk); #1;
    w1.wr_en = 1'b0;
    n_tests++; if (w1.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_write got %b want 0", w1.wr_ready); end
    #2 n_rst = 1'b0;
    #1;
    n_tests++; if (w1.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", w1.wr_ready); end
    n_tests++; if (r1_d1 !== '0 || vm1 !== '0) begin n_fail++; $display("FAIL rm_cleared got %h / %h want 0", r1_d1, vm1); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_tests++; if (w1.wr_done !== 1'b0) begin n_fail++; $display("FAIL rm_done_in_reset got %b want 0", w1.wr_done); end
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (w1.wr_done !== 1'b0) begin n_fail++; $display("FAIL rm_done_after got %b want 0", w1.wr_done); end
    for (int i = 0; i < 32; i++) begin
      r1_a1 = 5'(i); #1;
      n_tests++; if (r1_d1 !== '0) begin n_fail++; $display("FAIL rm_reg%0d got %h want 0", i, r1_d1); end
    end
  endtask

  initial begin
    w1.wr_en = 1'b0; w1.waddr = '0; w1.wdata = '0; w1.vm = 1'b1;
    w2.wr_en = 1'b0; w2.waddr = '0; w2.wdata = '0; w2.vm = 1'b1;
    r1_a1 = '0; r1_a2 = '0; r2_a1 = '0; r2_a2 = '0;
    test_reset();
    test_unmasked();
    test_masked();
    test_illegal();
    test_lmul2();
    test_busy();
    test_lsu();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_register_file.md
Name: vec_register_file

Overview:
- Vector register file: 32 architectural vector registers, each VLEN bits wide.
- Sits directly downstream of vec_lsu and consumes its `vd_data` / `is_loaded` result to commit vector loads.
- Also serves two combinational source-read ports to the vector datapath and exposes v0 as the mask source.
- Writes go through a one-entry staging register and a two-state commit FSM, with a ready/done handshake and LMUL register grouping.

Parameters:
- VLEN, 512, bits per vector register
- SEW, 32, bits per element
- LMUL, 1, register grouping; legal values 1, 2, 4, 8
- NREG, 32, number of vector registers
- ADDR_W, 5, register index width ($clog2(NREG))
- ELEMS, VLEN*LMUL/SEW, elements per grouped write (16 at defaults)

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- raddr_1  input  ADDR_W  source register 1 index (vs1)
- raddr_2  input  ADDR_W  source register 2 index (vs2)
- rdata_1  output  VLEN*LMUL  grouped data of vs1
- rdata_2  output  VLEN*LMUL  grouped data of vs2
- vmask  output  VLEN  current contents of v0
- wr_en  input  1  write request; driven by vec_lsu `is_loaded` for loads
- waddr  input  ADDR_W  destination register index (vd)
- wdata  input  VLEN*LMUL  write data; vec_lsu `vd_data` for loads
- vm  input  1  0 = masked by v0, 1 = unmasked
- wr_ready  output  1  staging register free, request accepted
- wr_done  output  1  one-cycle pulse after commit
- wr_err  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset, asynchronous on n_rst low:
  - all registers cleared to 0; state to IDLE
  - wr_ready = 1, wr_done = 0, wr_err = 0
  - rdata_1, rdata_2 and vmask read 0 while in reset
- Reads are combinational:
  - rdata_k = concatenation of reg[raddr_k + LMUL-1] down to reg[raddr_k]; the lowest register sits in the LSBs.
  - A misaligned raddr (raddr % LMUL != 0) returns 0.
  - An index beyond NREG-1 within a group returns 0 for that slice.
- No write-to-read bypass: a read in the same cycle as a commit returns the old value.
- FSM, two states, IDLE and WRITE:
  - IDLE, wr_ready = 1:
    - On a rising edge with wr_en = 1, a legal request captures waddr/wdata/vm into staging and moves to WRITE.
    - An illegal request is dropped, wr_err pulses the next cycle, and the state stays IDLE.
  - WRITE, wr_ready = 0:
    - At the next edge the staged data is committed to the array, the state returns to IDLE, and wr_done is high for exactly the following cycle.
    - wr_en asserted while in WRITE is ignored; no queuing; the requester must hold until wr_ready.
- Latency: the request edge is E0 and the commit edge is E1. New data is visible on the read ports and wr_done is high in the cycle after E1. Back-to-back throughput is one write per 2 cycles.
- Illegal requests (cause wr_err):
  - waddr % LMUL != 0
  - waddr + LMUL > NREG
  - vm = 0 with waddr = 0 (a masked write must not target v0)
- Masking:
  - vm = 1: all ELEMS elements are written.
  - vm = 0: element i (bits i*SEW +: SEW of the group) is written only if v0[i] = 1, with v0 sampled at the commit edge; otherwise the old element is kept.
  - v0 bits at index ELEMS and above are ignored.
- Simultaneous events: wr_done and wr_err can never coincide, because an error is only possible from IDLE.
- Reset mid-operation: a staged write is discarded, no commit happens, and wr_done does not pulse.

Decomposition:
- Package vec_regfile_pkg holds:
  - the constants VLEN, SEW, NREG, ADDR_W
  - a `typedef enum logic {IDLE, WRITE} wb_state_e`
  - a typedef for the staging struct {addr, data, vm}
- One sub-module, vec_mask_merge: combinational per-element merge of new/old data under v0 and vm. It is instantiated once in the commit path.

Test Plan:
- Reset, then read all 32 registers -> rdata_1 = rdata_2 = 0 and vmask = 0; wr_ready = 1 and wr_done = 0.
- Unmasked write, vm=1, waddr=3, wdata=512'hA5..A5, one-cycle wr_en:
  - wr_ready drops for 1 cycle; wr_done pulses 2 cycles after the request.
  - raddr_1=3 then reads A5..A5; reading register 3 during the commit cycle returns 0 (no bypass).
- Masked write:
  - First write v0=16'h00FF unmasked.
  - Then write vm=0, waddr=5, wdata all 1s.
  - Expect reg5 elements 0-7 = FFFFFFFF and elements 8-15 = 0.
- Illegal requests:
  - vm=0, waddr=0 -> wr_err pulses 1 cycle later, no wr_done, v0 unchanged.
  - With LMUL=2, waddr=3 -> wr_err.
  - With LMUL=2, waddr=4 -> registers 4 and 5 written; wr_done.
- Busy and reset cases:
  - Assert wr_en during WRITE with waddr=7 -> ignored, and reg7 is unchanged.
  - Assert n_rst low in the WRITE state -> no commit, no wr_done; all registers 0 after reset.
- LSU integration: drive wdata/wr_en from vec_lsu loading 16 words from base 0x200 -> destination register equals the memory words in element order, with exactly one wr_done.
